// File: rtl/imem_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, the IF fetch port, the loader port and the memory macro.
interface imem_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  fetch_req_i;
   logic [ADDR_WIDTH-1:0] fetch_addr_i;
   logic                  fetch_gnt_o;
   logic                  fetch_rvalid_o;
   logic [DATA_WIDTH-1:0] fetch_rdata_o;
   logic                  pc_we_o;
   logic                  ld_req_i;
   logic                  ld_we_i;
   logic [ADDR_WIDTH-1:0] ld_addr_i;
   logic [DATA_WIDTH-1:0] ld_wdata_i;
   logic                  ld_gnt_o;
   logic                  ld_rvalid_o;
   logic [DATA_WIDTH-1:0] ld_rdata_o;
   logic                  ld_done_i;
   logic                  mem_en_o;
   logic                  mem_we_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;

   modport slave (
      input  fetch_req_i, fetch_addr_i, ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i,
             ld_done_i, mem_rdata_i,
      output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, pc_we_o, ld_gnt_o, ld_rvalid_o,
             ld_rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output fetch_req_i, fetch_addr_i, ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i,
             ld_done_i, mem_rdata_i,
      input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, pc_we_o, ld_gnt_o, ld_rvalid_o,
             ld_rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between IF fetch and the loader/debug port,
// with a loader-only boot phase and a fetch-priority run phase with anti-starvation.
module imem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_STARVE = 4
) (
   input  logic           clk,
   input  logic           rst,
   imem_arbiter_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(MAX_STARVE + 1);

   typedef enum logic {ST_BOOT, ST_RUN} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_t;

   state_t                r_state, w_state_nxt;
   owner_t                r_owner, w_owner_nxt;
   logic [CNT_W-1:0]      r_starve, w_starve_nxt;
   logic [DATA_WIDTH-1:0] r_fetch_rdata, r_ld_rdata;
   logic                  w_fetch_gnt, w_ld_gnt;
   logic [ADDR_WIDTH-1:0] w_mem_addr;

   // Next state and grant decode; reset suppresses every grant
   always_comb begin
      w_state_nxt = r_state;
      w_fetch_gnt = 1'b0;
      w_ld_gnt    = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_BOOT: begin
               w_ld_gnt = bus.ld_req_i;
               if (bus.ld_done_i) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
               if (bus.ld_req_i && (r_starve == CNT_W'(MAX_STARVE))) w_ld_gnt    = 1'b1;
               else if (bus.fetch_req_i)                             w_fetch_gnt = 1'b1;
               else if (bus.ld_req_i)                                w_ld_gnt    = 1'b1;
            end
         endcase
      end
   end

   // Starvation counter and read-return ownership
   always_comb begin
      w_starve_nxt = r_starve;
      if (!bus.ld_req_i || w_ld_gnt)               w_starve_nxt = '0;
      else if (r_starve != CNT_W'(MAX_STARVE))    w_starve_nxt = r_starve + CNT_W'(1);

      w_owner_nxt = OWN_NONE;
      if (w_fetch_gnt)                   w_owner_nxt = OWN_FETCH;
      else if (w_ld_gnt && !bus.ld_we_i) w_owner_nxt = OWN_LOAD;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_BOOT;
         r_owner       <= OWN_NONE;
         r_starve      <= '0;
         r_fetch_rdata <= '0;
         r_ld_rdata    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_owner  <= w_owner_nxt;
         r_starve <= w_starve_nxt;
         if (r_owner == OWN_FETCH) r_fetch_rdata <= bus.mem_rdata_i;
         if (r_owner == OWN_LOAD)  r_ld_rdata    <= bus.mem_rdata_i;
      end
   end

   assign w_mem_addr      = w_ld_gnt ? bus.ld_addr_i : bus.fetch_addr_i;

   assign bus.fetch_gnt_o = w_fetch_gnt;
   assign bus.pc_we_o     = w_fetch_gnt;
   assign bus.ld_gnt_o    = w_ld_gnt;
   assign bus.mem_en_o    = w_fetch_gnt | w_ld_gnt;
   assign bus.mem_we_o    = w_ld_gnt & bus.ld_we_i;
   assign bus.mem_addr_o  = w_mem_addr;
   assign bus.mem_wdata_o = bus.ld_wdata_i;

   // Read data passes straight from memory on the return cycle, otherwise holds the last value
   assign bus.fetch_rvalid_o = !rst && (r_owner == OWN_FETCH);
   assign bus.ld_rvalid_o    = !rst && (r_owner == OWN_LOAD);
   assign bus.fetch_rdata_o  = rst ? DATA_WIDTH'(0)
                             : ((r_owner == OWN_FETCH) ? bus.mem_rdata_i : r_fetch_rdata);
   assign bus.ld_rdata_o     = rst ? DATA_WIDTH'(0)
                             : ((r_owner == OWN_LOAD) ? bus.mem_rdata_i : r_ld_rdata);
endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed vector table plus constrained-random traffic
// against a cycle-level reference model with its own memory image.
module tb_imem_arbiter;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;
   localparam int unsigned MAX_STARVE = 4;

   typedef struct {
      logic          rst, fr;
      logic [AW-1:0] fa;
      logic          lr, lw;
      logic [AW-1:0] la;
      logic [DW-1:0] lwd;
      logic          ld;
   } in_t;

   typedef struct {
      logic          fg, lg, fv, lv;
      logic [DW-1:0] fd, ldat;
   } out_t;

   typedef struct {
      in_t           i;
      logic          efg, elg, efv, elv;
      logic [DW-1:0] efd, eld;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   imem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STARVE(MAX_STARVE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Memory macro: synchronous read, write on enable
   bit   [DW-1:0] env_mem [1024];
   logic [DW-1:0] env_rdata = '0;
   always @(posedge clk) begin
      if (bus.mem_en_o) begin
         if (bus.mem_we_o) env_mem[bus.mem_addr_o] <= bus.mem_wdata_o;
         else              env_rdata <= env_mem[bus.mem_addr_o];
      end
   end
   assign bus.mem_rdata_i = env_rdata;

   // Reference model state
   bit   [DW-1:0] ref_mem [1024];
   bit            m_run = 1'b0;
   int            m_starve = 0;
   int            m_pend = 0;          // 0 none, 1 fetch read outstanding, 2 loader read outstanding
   logic [DW-1:0] m_pend_data = '0;
   logic [DW-1:0] m_last_f = '0, m_last_l = '0;
   bit            m_fg, m_lg;

   int n_checks = 0;
   int n_errors = 0;

   function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic in_t mk(bit r, bit fr, int fa, bit lr, bit lw, int la, logic [DW-1:0] lwd, bit ld);
      in_t v;
      v.rst = r; v.fr = fr; v.fa = AW'(fa); v.lr = lr; v.lw = lw;
      v.la = AW'(la); v.lwd = lwd; v.ld = ld;
      return v;
   endfunction

   vec_t tbl[$];

   function automatic void add(in_t i, bit efg, bit elg, bit efv, logic [DW-1:0] efd,
                               bit elv, logic [DW-1:0] eld);
      vec_t t;
      t.i = i; t.efg = efg; t.elg = elg; t.efv = efv; t.efd = efd; t.elv = elv; t.eld = eld;
      tbl.push_back(t);
   endfunction

   // Apply one cycle of inputs, check against the model, then advance the model
   task automatic step(input in_t v, output out_t a);
      bit            e_fg, e_lg, e_fv, e_lv;
      logic [DW-1:0] e_fd, e_ld;
      rst              = v.rst;
      bus.fetch_req_i  = v.fr;
      bus.fetch_addr_i = v.fa;
      bus.ld_req_i     = v.lr;
      bus.ld_we_i      = v.lw;
      bus.ld_addr_i    = v.la;
      bus.ld_wdata_i   = v.lwd;
      bus.ld_done_i    = v.ld;
      @(negedge clk);
      e_fg = 1'b0; e_lg = 1'b0; e_fv = 1'b0; e_lv = 1'b0; e_fd = '0; e_ld = '0;
      if (!v.rst) begin
         if (!m_run) e_lg = v.lr;
         else begin
            e_lg = v.lr && (m_starve >= int'(MAX_STARVE) || !v.fr);
            e_fg = v.fr && !e_lg;
         end
         e_fv = (m_pend == 1);
         e_lv = (m_pend == 2);
         e_fd = e_fv ? m_pend_data : m_last_f;
         e_ld = e_lv ? m_pend_data : m_last_l;
      end
      a.fg = bus.fetch_gnt_o;    a.lg = bus.ld_gnt_o;
      a.fv = bus.fetch_rvalid_o; a.lv = bus.ld_rvalid_o;
      a.fd = bus.fetch_rdata_o;  a.ldat = bus.ld_rdata_o;
      chk("fetch_gnt", DW'(a.fg), DW'(e_fg));
      chk("ld_gnt", DW'(a.lg), DW'(e_lg));
      chk("pc_we", DW'(bus.pc_we_o), DW'(e_fg));
      chk("mem_en", DW'(bus.mem_en_o), DW'(e_fg | e_lg));
      chk("mem_we", DW'(bus.mem_we_o), DW'(e_lg & v.lw));
      chk("fetch_rvalid", DW'(a.fv), DW'(e_fv));
      chk("ld_rvalid", DW'(a.lv), DW'(e_lv));
      chk("fetch_rdata", a.fd, e_fd);
      chk("ld_rdata", a.ldat, e_ld);
      if (e_fg | e_lg) chk("mem_addr", DW'(bus.mem_addr_o), DW'(e_lg ? v.la : v.fa));
      if (e_lg & v.lw) chk("mem_wdata", bus.mem_wdata_o, v.lwd);
      m_fg = e_fg; m_lg = e_lg;
      if (v.rst) begin
         m_run = 1'b0; m_starve = 0; m_pend = 0; m_last_f = '0; m_last_l = '0;
      end else begin
         if (e_fv) m_last_f = m_pend_data;
         if (e_lv) m_last_l = m_pend_data;
         m_pend = 0;
         if (e_fg) begin
            m_pend = 1; m_pend_data = ref_mem[v.fa];
         end else if (e_lg && !v.lw) begin
            m_pend = 2; m_pend_data = ref_mem[v.la];
         end
         if (e_lg && v.lw) ref_mem[v.la] = v.lwd;
         if (v.lr && !e_lg) m_starve = (m_starve < int'(MAX_STARVE)) ? m_starve + 1 : m_starve;
         else               m_starve = 0;
         if (v.ld) m_run = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      out_t a;
      in_t  cur;
      bit   hold_f, hold_l;

      // Reset held two cycles; a fetch request in reset/BOOT is never granted
      add(mk(1, 1, 0, 0, 0, 0, 0, 0),           0, 0, 0, 0, 0, 0);
      add(mk(1, 1, 0, 1, 1, 0, 0, 0),           0, 0, 0, 0, 0, 0);
      add(mk(0, 1, 0, 0, 0, 0, 0, 0),           0, 0, 0, 0, 0, 0);
      // Boot load of 0..9, then done
      for (int i = 0; i < 10; i++) add(mk(0, 0, 0, 1, 1, i, DW'(i), 0), 0, 1, 0, 0, 0, 0);
      add(mk(0, 0, 0, 0, 0, 0, 0, 1),           0, 0, 0, 0, 0, 0);
      // Back-to-back fetches of 0..9
      for (int i = 0; i < 10; i++) add(mk(0, 1, i, 0, 0, 0, 0, 0), 1, 0, i > 0, DW'(i - 1), 0, 0);
      add(mk(0, 0, 0, 0, 0, 0, 0, 0),           0, 0, 1, 32'd9, 0, 0);
      // Both requesting: four fetch grants, loader forced on the fifth
      add(mk(0, 1, 0, 1, 0, 3, 0, 0),           1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(mk(0, 1, 0, 1, 0, 3, 0, 0), 1, 0, 1, 0, 0, 0);
      add(mk(0, 1, 0, 1, 0, 3, 0, 0),           0, 1, 1, 0, 0, 0);
      add(mk(0, 1, 0, 0, 0, 0, 0, 0),           1, 0, 0, 0, 1, 32'd3);
      add(mk(0, 0, 0, 0, 0, 0, 0, 0),           0, 0, 1, 0, 0, 0);
      // Loader read with fetch idle
      add(mk(0, 0, 0, 1, 0, 3, 0, 0),           0, 1, 0, 0, 0, 0);
      add(mk(0, 0, 0, 0, 0, 0, 0, 0),           0, 0, 0, 0, 1, 32'd3);
      // Done together with a write, then fetch it back
      add(mk(1, 0, 0, 0, 0, 0, 0, 0),           0, 0, 0, 0, 0, 0);
      add(mk(0, 0, 0, 0, 0, 0, 0, 0),           0, 0, 0, 0, 0, 0);
      add(mk(0, 0, 0, 1, 1, 5, 32'hA5, 1),      0, 1, 0, 0, 0, 0);
      add(mk(0, 1, 5, 0, 0, 0, 0, 0),           1, 0, 0, 0, 0, 0);
      add(mk(0, 1, 5, 0, 0, 0, 0, 0),           1, 0, 1, 32'hA5, 0, 0);
      // Reset right after a granted fetch drops its return and re-enters BOOT
      add(mk(1, 0, 0, 0, 0, 0, 0, 0),           0, 0, 0, 0, 0, 0);
      add(mk(0, 1, 5, 0, 0, 0, 0, 0),           0, 0, 0, 0, 0, 0);

      for (int k = 0; k < tbl.size(); k++) begin
         step(tbl[k].i, a);
         chk($sformatf("vec%0d_fetch_gnt", k), DW'(a.fg), DW'(tbl[k].efg));
         chk($sformatf("vec%0d_ld_gnt", k), DW'(a.lg), DW'(tbl[k].elg));
         chk($sformatf("vec%0d_fetch_rvalid", k), DW'(a.fv), DW'(tbl[k].efv));
         chk($sformatf("vec%0d_ld_rvalid", k), DW'(a.lv), DW'(tbl[k].elv));
         if (tbl[k].efv) chk($sformatf("vec%0d_fetch_rdata", k), a.fd, tbl[k].efd);
         if (tbl[k].elv) chk($sformatf("vec%0d_ld_rdata", k), a.ldat, tbl[k].eld);
      end

      // Random traffic; requesters hold their request until granted
      cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
      hold_f = 1'b0; hold_l = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (!hold_f) begin
            cur.fr = ($urandom_range(0, 9) < 6);
            cur.fa = AW'($urandom_range(0, 15));
         end
         if (!hold_l) begin
            cur.lr  = ($urandom_range(0, 9) < 4);
            cur.lw  = $urandom_range(0, 1) == 1;
            cur.la  = AW'($urandom_range(0, 15));
            cur.lwd = DW'($urandom);
         end
         cur.rst = ($urandom_range(0, 99) == 0);
         cur.ld  = ($urandom_range(0, 29) == 0);
         step(cur, a);
         hold_f = !cur.rst && cur.fr && !m_fg;
         hold_l = !cur.rst && cur.lr && !m_lg;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
